// File: rtl/lq_dur_mon_if.sv
// lq_dur_mon_if: request/event inputs and measurement
// outputs of the load-queue duration monitor.
interface lq_dur_mon_if #(
    parameter int NUM_MON  = 4,
    parameter int IDX_W    = 6,
    parameter int TS_W     = 14,
    parameter int DROP_LSB = 4,
    parameter int ACC_W    = 16
);
    localparam int DUR_W = TS_W - DROP_LSB;

    logic                     sample_req;
    logic [IDX_W-1:0]         sample_idx;
    logic [TS_W-1:0]          timestamp;
    logic                     exec_vld;
    logic [IDX_W-1:0]         exec_idx;
    logic                     retire_vld;
    logic [IDX_W-1:0]         retire_idx;
    logic                     flush;
    logic [NUM_MON-1:0]       mon_busy;
    logic [NUM_MON-1:0]       mon_vld;
    logic [NUM_MON*DUR_W-1:0] dur_exec;
    logic [NUM_MON*DUR_W-1:0] dur_retire;
    logic [ACC_W-1:0]         done_cnt;
    logic [ACC_W-1:0]         sum_retire;
    logic [DUR_W-1:0]         max_retire;
    logic [ACC_W-1:0]         drop_cnt;

    modport master (
        output sample_req, sample_idx, timestamp,
        output exec_vld, exec_idx,
        output retire_vld, retire_idx, flush,
        input  mon_busy, mon_vld, dur_exec, dur_retire,
        input  done_cnt, sum_retire, max_retire, drop_cnt
    );

    modport slave (
        input  sample_req, sample_idx, timestamp,
        input  exec_vld, exec_idx,
        input  retire_vld, retire_idx, flush,
        output mon_busy, mon_vld, dur_exec, dur_retire,
        output done_cnt, sum_retire, max_retire, drop_cnt
    );
endinterface

// File: rtl/lq_dur_mon.sv
// lq_dur_mon: multi-channel dispatch->exec/retire latency
// monitor with saturating durations and aggregate stats.
module lq_dur_mon #(
    parameter int NUM_MON  = 4,
    parameter int IDX_W    = 6,
    parameter int TS_W     = 14,
    parameter int DROP_LSB = 4,
    parameter int ACC_W    = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    lq_dur_mon_if.slave  bus
);
    localparam int DUR_W = TS_W - DROP_LSB;

    typedef enum logic [1:0] {IDLE, ARMED, EXECD} st_e;

    st_e              st_q [NUM_MON];
    st_e              st_d [NUM_MON];
    logic [DUR_W-1:0] start_q [NUM_MON];
    logic [DUR_W-1:0] dex_q [NUM_MON];
    logic [DUR_W-1:0] dret_q [NUM_MON];
    logic [IDX_W-1:0] idx_q [NUM_MON];
    logic [NUM_MON-1:0] sat_q, vld_q;
    logic [ACC_W-1:0] done_q, sum_q, drop_q;
    logic [DUR_W-1:0] max_q;

    logic [DUR_W-1:0] ts_c;
    logic [DUR_W-1:0] elapsed [NUM_MON];
    logic [DUR_W-1:0] cap [NUM_MON];
    logic [NUM_MON-1:0] active, hit_x, hit_r, dup_v, alloc;
    logic             dup, req_ok, alloc_en, drop_ev;
    logic             ret_any;
    logic [DUR_W-1:0] ret_val;
    logic [ACC_W:0]   sum_ext;
    logic             ts_unused;

    assign ts_c      = bus.timestamp[TS_W-1:DROP_LSB];
    assign ts_unused = ^bus.timestamp[DROP_LSB-1:0];

    // Per-channel match, elapsed time and captured value
    always_comb begin
        active  = '0;
        hit_x   = '0;
        hit_r   = '0;
        dup_v   = '0;
        ret_val = '0;
        for (int n = 0; n < NUM_MON; n++) begin
            active[n]  = (st_q[n] != IDLE);
            elapsed[n] = ts_c - start_q[n];
            cap[n]     = sat_q[n] ? '1 : elapsed[n];
            hit_x[n]   = active[n] && bus.exec_vld &&
                         (bus.exec_idx == idx_q[n]);
            hit_r[n]   = active[n] && bus.retire_vld &&
                         (bus.retire_idx == idx_q[n]);
            dup_v[n]   = active[n] &&
                         (bus.sample_idx == idx_q[n]);
            if (hit_r[n]) ret_val = ret_val | cap[n];
        end
        ret_any = |hit_r;
        dup     = |dup_v;
    end

    // Lowest idle channel (start-of-cycle) wins allocation
    always_comb begin
        alloc = '0;
        for (int n = NUM_MON - 1; n >= 0; n--) begin
            if (!active[n]) alloc = NUM_MON'(1) << n;
        end
        req_ok   = bus.sample_req && !bus.flush;
        alloc_en = req_ok && !dup && !(&active);
        drop_ev  = req_ok && (dup || (&active));
        sum_ext  = {1'b0, sum_q} +
                   {{(ACC_W + 1 - DUR_W){1'b0}}, ret_val};
    end

    // Channel FSM next state
    always_comb begin
        for (int n = 0; n < NUM_MON; n++) begin
            st_d[n] = st_q[n];
            if (bus.flush) begin
                st_d[n] = IDLE;
            end else begin
                unique case (st_q[n])
                    IDLE:  if (alloc_en && alloc[n]) st_d[n] = ARMED;
                    ARMED: if (hit_r[n])      st_d[n] = IDLE;
                           else if (hit_x[n]) st_d[n] = EXECD;
                    EXECD: if (hit_r[n])      st_d[n] = IDLE;
                    default: st_d[n] = IDLE;
                endcase
            end
        end
    end

    // Channel FSM state register
    always_ff @(posedge clk) begin
        for (int n = 0; n < NUM_MON; n++) begin
            if (!reset_n) st_q[n] <= IDLE;
            else          st_q[n] <= st_d[n];
        end
    end

    // Per-channel start/index/saturation and captured durations
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sat_q <= '0;
            vld_q <= '0;
            for (int n = 0; n < NUM_MON; n++) begin
                start_q[n] <= '0;
                idx_q[n]   <= '0;
                dex_q[n]   <= '0;
                dret_q[n]  <= '0;
            end
        end else if (!bus.flush) begin
            for (int n = 0; n < NUM_MON; n++) begin
                if (alloc_en && alloc[n]) begin
                    start_q[n] <= ts_c;
                    idx_q[n]   <= bus.sample_idx;
                    sat_q[n]   <= 1'b0;
                    vld_q[n]   <= 1'b0;
                end else if (active[n]) begin
                    if (elapsed[n] == '1) sat_q[n] <= 1'b1;
                    if (hit_r[n]) begin
                        dret_q[n] <= cap[n];
                        vld_q[n]  <= 1'b1;
                        if (st_q[n] == ARMED) dex_q[n] <= cap[n];
                    end else if (hit_x[n] && st_q[n] == ARMED) begin
                        dex_q[n] <= cap[n];
                    end
                end
            end
        end
    end

    // Aggregate statistics, all saturating
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_q <= '0;
            sum_q  <= '0;
            max_q  <= '0;
            drop_q <= '0;
        end else if (!bus.flush) begin
            if (ret_any) begin
                if (done_q != '1) done_q <= done_q + 1'b1;
                sum_q <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                if (ret_val > max_q) max_q <= ret_val;
            end
            if (drop_ev && drop_q != '1) drop_q <= drop_q + 1'b1;
        end
    end

    // Output packing
    always_comb begin
        bus.dur_exec   = '0;
        bus.dur_retire = '0;
        for (int n = 0; n < NUM_MON; n++) begin
            bus.dur_exec[n*DUR_W +: DUR_W]   = dex_q[n];
            bus.dur_retire[n*DUR_W +: DUR_W] = dret_q[n];
        end
        bus.mon_busy   = active;
        bus.mon_vld    = vld_q;
        bus.done_cnt   = done_q;
        bus.sum_retire = sum_q;
        bus.max_retire = max_q;
        bus.drop_cnt   = drop_q;
    end
endmodule

// File: tb/tb_lq_dur_mon.sv
// tb_lq_dur_mon: directed plus random checks of lq_dur_mon
// against a transaction-level latency model.
module tb_lq_dur_mon;
    localparam int NM    = 4;
    localparam int IW    = 6;
    localparam int TW    = 14;
    localparam int DL    = 4;
    localparam int AW    = 16;
    localparam int DW    = TW - DL;
    localparam int DMAX  = (1 << DW) - 1;
    localparam int AMAX  = (1 << AW) - 1;

    logic clk;
    logic reset_n;
    int   tests;
    int   fails;

    lq_dur_mon_if #(NM, IW, TW, DL, AW) bus ();

    lq_dur_mon #(
        .NUM_MON(NM), .IDX_W(IW), .TS_W(TW),
        .DROP_LSB(DL), .ACC_W(AW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each tracked entry remembers its absolute dispatch
    // time in units; a duration is simply min(now-start, max).
    longint abs_ts;
    bit     m_act [NM];
    bit     m_ex  [NM];
    longint m_st  [NM];
    int     m_idx [NM];
    int     m_dex [NM];
    int     m_dret[NM];
    bit     m_vld [NM];
    int     m_done, m_sum, m_max, m_drop;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit rn, input bit req,
                              input int sidx, input bit ev,
                              input int eidx, input bit rv,
                              input int ridx, input bit fl);
        bit     was[NM];
        longint now;
        longint d;
        bit     dup;
        int     fr;
        if (!rn) begin
            for (int n = 0; n < NM; n++) begin
                m_act[n] = 0; m_ex[n] = 0; m_st[n] = 0;
                m_idx[n] = 0; m_dex[n] = 0; m_dret[n] = 0;
                m_vld[n] = 0;
            end
            m_done = 0; m_sum = 0; m_max = 0; m_drop = 0;
            return;
        end
        if (fl) begin
            for (int n = 0; n < NM; n++) m_act[n] = 0;
            return;
        end
        now = abs_ts >> DL;
        was = m_act;
        dup = 0;
        fr  = -1;
        for (int n = NM - 1; n >= 0; n--) begin
            if (was[n] && m_idx[n] == sidx) dup = 1;
            if (!was[n]) fr = n;
        end
        for (int n = 0; n < NM; n++) begin
            if (!was[n]) continue;
            d = now - m_st[n];
            if (d > DMAX) d = DMAX;
            if (rv && ridx == m_idx[n]) begin
                m_dret[n] = int'(d);
                if (!m_ex[n]) m_dex[n] = int'(d);
                m_vld[n] = 1;
                m_act[n] = 0;
                m_done = (m_done + 1 > AMAX) ? AMAX : m_done + 1;
                m_sum  = (m_sum + int'(d) > AMAX) ? AMAX
                                                  : m_sum + int'(d);
                if (int'(d) > m_max) m_max = int'(d);
            end else if (ev && eidx == m_idx[n] && !m_ex[n]) begin
                m_dex[n] = int'(d);
                m_ex[n]  = 1;
            end
        end
        if (req) begin
            if (dup || fr < 0) begin
                if (m_drop < AMAX) m_drop++;
            end else begin
                m_act[fr] = 1; m_ex[fr] = 0; m_st[fr] = now;
                m_idx[fr] = sidx; m_vld[fr] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [NM-1:0]    eb, ev;
        logic [NM*DW-1:0] ex, er;
        eb = '0; ev = '0; ex = '0; er = '0;
        for (int n = 0; n < NM; n++) begin
            eb[n] = m_act[n];
            ev[n] = m_vld[n];
            ex[n*DW +: DW] = DW'(m_dex[n]);
            er[n*DW +: DW] = DW'(m_dret[n]);
        end
        check("mon_busy", 64'(bus.mon_busy), 64'(eb));
        check("mon_vld", 64'(bus.mon_vld), 64'(ev));
        check("dur_exec", 64'(bus.dur_exec), 64'(ex));
        check("dur_retire", 64'(bus.dur_retire), 64'(er));
        check("done_cnt", 64'(bus.done_cnt), 64'(m_done));
        check("sum_retire", 64'(bus.sum_retire), 64'(m_sum));
        check("max_retire", 64'(bus.max_retire), 64'(m_max));
        check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
    endtask

    task automatic step(input bit req, input int sidx,
                        input bit ev, input int eidx,
                        input bit rv, input int ridx,
                        input bit fl);
        @(negedge clk);
        bus.sample_req = req;
        bus.sample_idx = IW'(sidx);
        bus.exec_vld   = ev;
        bus.exec_idx   = IW'(eidx);
        bus.retire_vld = rv;
        bus.retire_idx = IW'(ridx);
        bus.flush      = fl;
        bus.timestamp  = abs_ts[TW-1:0];
        model_step(reset_n, req, sidx, ev, eidx, rv, ridx, fl);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        abs_ts = 0;
        reset_n = 1'b0;
        bus.sample_req = 0; bus.sample_idx = '0;
        bus.exec_vld = 0;   bus.exec_idx = '0;
        bus.retire_vld = 0; bus.retire_idx = '0;
        bus.flush = 0;      bus.timestamp = '0;

        idle();
        idle();
        check("rst_busy", 64'(bus.mon_busy), 64'h0);
        reset_n = 1'b1;

        abs_ts = 64'h100;
        step(1, 5, 0, 0, 0, 0, 0);
        abs_ts = 64'h180;
        step(0, 0, 1, 5, 0, 0, 0);
        abs_ts = 64'h300;
        step(0, 0, 0, 0, 1, 5, 0);
        check("basic_dex", 64'(bus.dur_exec[0 +: DW]), 64'h008);
        check("basic_dret", 64'(bus.dur_retire[0 +: DW]), 64'h020);
        check("basic_vld", 64'(bus.mon_vld[0]), 64'h1);
        check("basic_done", 64'(bus.done_cnt), 64'h1);
        check("basic_max", 64'(bus.max_retire), 64'h020);

        for (int i = 1; i <= 5; i++) step(1, i, 0, 0, 0, 0, 0);
        check("conc_busy", 64'(bus.mon_busy), 64'hF);
        check("conc_drop1", 64'(bus.drop_cnt), 64'h1);
        step(1, 2, 0, 0, 0, 0, 0);
        check("dup_drop2", 64'(bus.drop_cnt), 64'h2);

        abs_ts += 64'h100;
        step(0, 0, 0, 0, 1, 3, 0);
        check("impl_dex", 64'(bus.dur_exec[2*DW +: DW]), 64'h010);
        check("impl_dret", 64'(bus.dur_retire[2*DW +: DW]), 64'h010);
        abs_ts += 64'h50;
        step(0, 0, 1, 4, 1, 4, 0);
        check("same_dex", 64'(bus.dur_exec[3*DW +: DW]), 64'h015);
        check("same_dret", 64'(bus.dur_retire[3*DW +: DW]), 64'h015);

        step(1, 9, 0, 0, 0, 0, 0);
        check("fl_pre", 64'(bus.mon_busy), 64'h7);
        step(1, 10, 0, 0, 0, 0, 1);
        check("fl_busy", 64'(bus.mon_busy), 64'h0);
        check("fl_done", 64'(bus.done_cnt), 64'h3);
        check("fl_drop", 64'(bus.drop_cnt), 64'h2);

        step(1, 6, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1100; i++) begin
            abs_ts += 16;
            idle();
        end
        step(0, 0, 0, 0, 1, 6, 0);
        check("sat_dret", 64'(bus.dur_retire[0 +: DW]), 64'h3FF);
        check("sat_max", 64'(bus.max_retire), 64'h3FF);
        check("sat_sum", 64'(bus.sum_retire), 64'h444);

        step(1, 7, 0, 0, 0, 0, 0);
        abs_ts += 32;
        step(1, 7, 0, 0, 1, 7, 0);
        check("ord_busy", 64'(bus.mon_busy), 64'h0);
        check("ord_drop", 64'(bus.drop_cnt), 64'h3);
        check("ord_dret", 64'(bus.dur_retire[0 +: DW]), 64'h002);
        step(1, 7, 0, 0, 0, 0, 0);
        check("ord_realloc", 64'(bus.mon_busy), 64'h1);

        abs_ts += 16;
        reset_n = 1'b0;
        idle();
        check("mrst_busy", 64'(bus.mon_busy), 64'h0);
        check("mrst_drop", 64'(bus.drop_cnt), 64'h0);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 1, 7, 0);
        check("mrst_ign", 64'(bus.done_cnt), 64'h0);

        for (int i = 0; i < 600; i++) begin
            abs_ts += $urandom_range(0, 16);
            step($urandom_range(0, 9) < 4,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 4,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 9) < 3,
                 int'($urandom_range(0, 7)),
                 $urandom_range(0, 39) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
